// File: rtl/control_hamming_if.sv
// Handshake and result bundle between a codeword producer/consumer and the
// Hamming SECDED decode controller.
interface control_hamming_if #(
  parameter int ANCHO_CONT = 8
);
  logic                  entrada_valida;
  logic                  entrada_lista;
  logic [7:0]            palabra;
  logic [7:0]            mascara_error;
  logic                  salida_valida;
  logic                  salida_acepta;
  logic [7:0]            recibido;
  logic [3:0]            dato_corregido;
  logic [2:0]            posicion_error;
  logic                  error_simple;
  logic                  error_doble;
  logic [ANCHO_CONT-1:0] contador_simple;
  logic [ANCHO_CONT-1:0] contador_doble;

  modport master (
    output entrada_valida, palabra, mascara_error, salida_acepta,
    input  entrada_lista, salida_valida, recibido, dato_corregido,
           posicion_error, error_simple, error_doble,
           contador_simple, contador_doble
  );

  modport slave (
    input  entrada_valida, palabra, mascara_error, salida_acepta,
    output entrada_lista, salida_valida, recibido, dato_corregido,
           posicion_error, error_simple, error_doble,
           contador_simple, contador_doble
  );
endinterface

// File: rtl/control_hamming.sv
// Sequencing controller for the 8-bit Hamming SECDED decode path: capture,
// syndrome, correction, and held delivery with saturating error counters.
module control_hamming #(
  parameter int ANCHO_CONT = 8,
  parameter bit INYECTAR   = 1'b1
) (
  input logic              reloj,
  input logic              reset,
  control_hamming_if.slave bus
);

  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    DECODIFICA = 2'd1,
    CORRIGE    = 2'd2,
    ENTREGA    = 2'd3
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [7:0]            recibido_q, recibido_d;
  logic [2:0]            sindrome_q, sindrome_d;
  logic                  paridad_q, paridad_d;
  logic [3:0]            dato_q, dato_d;
  logic [2:0]            posicion_q, posicion_d;
  logic                  simple_q, simple_d;
  logic                  doble_q, doble_d;
  logic                  valida_q, valida_d;
  logic [ANCHO_CONT-1:0] cont_simple_q, cont_simple_d;
  logic [ANCHO_CONT-1:0] cont_doble_q, cont_doble_d;
  logic [7:0]            corregida;
  logic                  es_simple, es_doble;

  always_comb begin
    estado_d      = estado_q;
    recibido_d    = recibido_q;
    sindrome_d    = sindrome_q;
    paridad_d     = paridad_q;
    dato_d        = dato_q;
    posicion_d    = posicion_q;
    simple_d      = simple_q;
    doble_d       = doble_q;
    valida_d      = valida_q;
    cont_simple_d = cont_simple_q;
    cont_doble_d  = cont_doble_q;
    corregida     = recibido_q;
    es_simple     = paridad_q;
    es_doble      = !paridad_q && (sindrome_q != 3'd0);

    case (estado_q)
      ESPERA: begin
        if (bus.entrada_valida) begin
          recibido_d = bus.palabra ^ (INYECTAR ? bus.mascara_error : 8'h00);
          estado_d   = DECODIFICA;
        end
      end
      DECODIFICA: begin
        sindrome_d = {recibido_q[4] ^ recibido_q[5] ^ recibido_q[6] ^ recibido_q[7],
                      recibido_q[2] ^ recibido_q[3] ^ recibido_q[6] ^ recibido_q[7],
                      recibido_q[1] ^ recibido_q[3] ^ recibido_q[5] ^ recibido_q[7]};
        paridad_d  = ^recibido_q;
        estado_d   = CORRIGE;
      end
      CORRIGE: begin
        // Odd overall parity with a nonzero syndrome points at the flipped bit;
        // a zero syndrome means only the parity bit itself was hit.
        if (paridad_q && (sindrome_q != 3'd0)) begin
          corregida = recibido_q ^ (8'h01 << sindrome_q);
        end
        dato_d     = {corregida[7], corregida[6], corregida[5], corregida[3]};
        posicion_d = sindrome_q;
        simple_d   = es_simple;
        doble_d    = es_doble;
        if (es_simple && (cont_simple_q != '1)) begin
          cont_simple_d = cont_simple_q + 1'b1;
        end
        if (es_doble && (cont_doble_q != '1)) begin
          cont_doble_d = cont_doble_q + 1'b1;
        end
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        // The valid flag rises one edge after entry; only a consumer that has
        // seen it high can retire the word.
        if (!valida_q) begin
          valida_d = 1'b1;
        end else if (bus.salida_acepta) begin
          valida_d = 1'b0;
          estado_d = ESPERA;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q      <= ESPERA;
      recibido_q    <= 8'h00;
      sindrome_q    <= 3'd0;
      paridad_q     <= 1'b0;
      dato_q        <= 4'h0;
      posicion_q    <= 3'd0;
      simple_q      <= 1'b0;
      doble_q       <= 1'b0;
      valida_q      <= 1'b0;
      cont_simple_q <= '0;
      cont_doble_q  <= '0;
    end else begin
      estado_q      <= estado_d;
      recibido_q    <= recibido_d;
      sindrome_q    <= sindrome_d;
      paridad_q     <= paridad_d;
      dato_q        <= dato_d;
      posicion_q    <= posicion_d;
      simple_q      <= simple_d;
      doble_q       <= doble_d;
      valida_q      <= valida_d;
      cont_simple_q <= cont_simple_d;
      cont_doble_q  <= cont_doble_d;
    end
  end

  assign bus.entrada_lista   = (estado_q == ESPERA);
  assign bus.salida_valida   = valida_q;
  assign bus.recibido        = recibido_q;
  assign bus.dato_corregido  = dato_q;
  assign bus.posicion_error  = posicion_q;
  assign bus.error_simple    = simple_q;
  assign bus.error_doble     = doble_q;
  assign bus.contador_simple = cont_simple_q;
  assign bus.contador_doble  = cont_doble_q;

endmodule

// File: tb/tb_control_hamming.sv
// Scoreboard bench: three controller builds (default, 2-bit counters, no
// injection) run in lockstep on the same stimulus against a behavioural model.
module tb_control_hamming;

  typedef struct packed {
    logic [7:0] rec;
    logic [3:0] dato;
    logic [2:0] pos;
    logic       es;
    logic       ed;
    logic [7:0] cs;
    logic [7:0] cd;
  } resultado_t;

  logic       reloj;
  logic       reset;
  logic       ent_valida;
  logic [7:0] palabra;
  logic [7:0] mascara;
  logic       sal_acepta;

  int total;
  int bad;

  resultado_t q_a[$];
  resultado_t q_b[$];
  resultado_t q_c[$];
  logic [7:0] cs_m[3];
  logic [7:0] cd_m[3];

  control_hamming_if #(.ANCHO_CONT(8)) if_a ();
  control_hamming_if #(.ANCHO_CONT(2)) if_b ();
  control_hamming_if #(.ANCHO_CONT(8)) if_c ();

  assign if_a.entrada_valida = ent_valida;
  assign if_a.palabra        = palabra;
  assign if_a.mascara_error  = mascara;
  assign if_a.salida_acepta  = sal_acepta;
  assign if_b.entrada_valida = ent_valida;
  assign if_b.palabra        = palabra;
  assign if_b.mascara_error  = mascara;
  assign if_b.salida_acepta  = sal_acepta;
  assign if_c.entrada_valida = ent_valida;
  assign if_c.palabra        = palabra;
  assign if_c.mascara_error  = mascara;
  assign if_c.salida_acepta  = sal_acepta;

  control_hamming #(.ANCHO_CONT(8), .INYECTAR(1'b1)) dut_a (
    .reloj(reloj), .reset(reset), .bus(if_a.slave)
  );
  control_hamming #(.ANCHO_CONT(2), .INYECTAR(1'b1)) dut_b (
    .reloj(reloj), .reset(reset), .bus(if_b.slave)
  );
  control_hamming #(.ANCHO_CONT(8), .INYECTAR(1'b0)) dut_c (
    .reloj(reloj), .reset(reset), .bus(if_c.slave)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Syndrome is the XOR of the positions of all set bits 1..7.
  function automatic resultado_t modelo(input logic [7:0] w, input logic [7:0] m, input bit inj,
                                        input logic [7:0] cs_prev, input logic [7:0] cd_prev,
                                        input int ancho);
    resultado_t e;
    logic [7:0] r;
    logic [7:0] c;
    logic [2:0] s;
    logic       st;
    logic [7:0] tope;
    r = inj ? (w ^ m) : w;
    s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r[i]) s = s ^ 3'(i);
    end
    st = ^r;
    c = r;
    if (st && s != 3'd0) c[s] = ~c[s];
    tope   = 8'((1 << ancho) - 1);
    e.rec  = r;
    e.dato = {c[7], c[6], c[5], c[3]};
    e.pos  = s;
    e.es   = st;
    e.ed   = !st && (s != 3'd0);
    e.cs   = (e.es && cs_prev < tope) ? cs_prev + 8'd1 : cs_prev;
    e.cd   = (e.ed && cd_prev < tope) ? cd_prev + 8'd1 : cd_prev;
    return e;
  endfunction

  task automatic checkInst(input string tag, input resultado_t e, input logic [7:0] rec,
                           input logic [3:0] dato, input logic [2:0] pos, input logic es,
                           input logic ed, input logic [7:0] cs, input logic [7:0] cd);
    checkOutput({tag, "_recibido"}, 32'(rec), 32'(e.rec));
    checkOutput({tag, "_dato"}, 32'(dato), 32'(e.dato));
    checkOutput({tag, "_posicion"}, 32'(pos), 32'(e.pos));
    checkOutput({tag, "_simple"}, 32'(es), 32'(e.es));
    checkOutput({tag, "_doble"}, 32'(ed), 32'(e.ed));
    checkOutput({tag, "_cont_simple"}, 32'(cs), 32'(e.cs));
    checkOutput({tag, "_cont_doble"}, 32'(cd), 32'(e.cd));
  endtask

  task automatic esperarLista();
    int n;
    n = 0;
    while (!if_a.entrada_lista && n < 20) begin
      @(posedge reloj);
      #1;
      n++;
    end
    checkOutput("lista", 32'(if_a.entrada_lista), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] w, input logic [7:0] m, input int hold);
    resultado_t e;
    resultado_t ea;
    int n;
    esperarLista();
    ent_valida = 1'b1;
    palabra    = w;
    mascara    = m;
    @(posedge reloj);
    e = modelo(w, m, 1'b1, cs_m[0], cd_m[0], 8); cs_m[0] = e.cs; cd_m[0] = e.cd; q_a.push_back(e);
    e = modelo(w, m, 1'b1, cs_m[1], cd_m[1], 2); cs_m[1] = e.cs; cd_m[1] = e.cd; q_b.push_back(e);
    e = modelo(w, m, 1'b0, cs_m[2], cd_m[2], 8); cs_m[2] = e.cs; cd_m[2] = e.cd; q_c.push_back(e);
    #1;
    ent_valida = 1'b0;
    palabra    = 8'($urandom);
    mascara    = 8'($urandom);
    n = 0;
    while (!if_a.salida_valida && n < 10) begin
      @(posedge reloj);
      #1;
      n++;
    end
    checkOutput("latencia", 32'(n), 32'd3);
    checkOutput("cola", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd3);
    ea = q_a.pop_front();
    checkInst("a", ea, if_a.recibido, if_a.dato_corregido, if_a.posicion_error,
              if_a.error_simple, if_a.error_doble, if_a.contador_simple, if_a.contador_doble);
    e = q_b.pop_front();
    checkInst("b", e, if_b.recibido, if_b.dato_corregido, if_b.posicion_error,
              if_b.error_simple, if_b.error_doble, 8'(if_b.contador_simple), 8'(if_b.contador_doble));
    e = q_c.pop_front();
    checkInst("c", e, if_c.recibido, if_c.dato_corregido, if_c.posicion_error,
              if_c.error_simple, if_c.error_doble, if_c.contador_simple, if_c.contador_doble);
    ent_valida = 1'b1;
    for (int k = 0; k < hold; k++) begin
      palabra = 8'($urandom);
      @(posedge reloj);
      #1;
      checkOutput("bp_lista", 32'(if_a.entrada_lista), 32'd0);
      checkOutput("bp_valida", 32'(if_a.salida_valida), 32'd1);
      checkOutput("bp_recibido", 32'(if_a.recibido), 32'(ea.rec));
      checkOutput("bp_dato", 32'(if_a.dato_corregido), 32'(ea.dato));
    end
    palabra    = ~ea.rec;
    sal_acepta = 1'b1;
    @(posedge reloj);
    #1;
    sal_acepta = 1'b0;
    ent_valida = 1'b0;
    checkOutput("valida_baja", 32'(if_a.salida_valida), 32'd0);
    checkOutput("lista_sube", 32'(if_a.entrada_lista), 32'd1);
    checkOutput("sin_captura", 32'(if_a.recibido), 32'(ea.rec));
  endtask

  task automatic resetMidDecode();
    esperarLista();
    ent_valida = 1'b1;
    palabra    = 8'hAA;
    mascara    = 8'h20;
    @(posedge reloj);
    #1;
    ent_valida = 1'b0;
    reset      = 1'b1;
    @(posedge reloj);
    #1;
    reset = 1'b0;
    checkOutput("rst_valida", 32'(if_a.salida_valida), 32'd0);
    checkOutput("rst_lista", 32'(if_a.entrada_lista), 32'd1);
    checkOutput("rst_recibido", 32'(if_a.recibido), 32'd0);
    checkOutput("rst_flags", 32'({if_a.error_simple, if_a.error_doble}), 32'd0);
    checkOutput("rst_cont_a", 32'({if_a.contador_simple, if_a.contador_doble}), 32'd0);
    checkOutput("rst_cont_b", 32'({if_b.contador_simple, if_b.contador_doble}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cs_m[i] = 8'd0;
      cd_m[i] = 8'd0;
    end
  endtask

  always @(negedge reloj) begin
    if (!reset && if_a.error_simple && if_a.error_doble) begin
      checkOutput("flags_exclusivos", 32'd1, 32'd0);
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    ent_valida = 1'b0;
    palabra    = 8'h00;
    mascara    = 8'h00;
    sal_acepta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cs_m[i] = 8'd0;
      cd_m[i] = 8'd0;
    end
    repeat (2) @(posedge reloj);
    #1;
    reset = 1'b0;
    checkOutput("reset_valida", 32'(if_a.salida_valida), 32'd0);
    checkOutput("reset_lista", 32'(if_a.entrada_lista), 32'd1);
    checkOutput("reset_salidas", 32'({if_a.recibido, if_a.dato_corregido, if_a.posicion_error}), 32'd0);
    checkOutput("reset_cont", 32'({if_a.contador_simple, if_a.contador_doble}), 32'd0);

    applyStimulus(8'hAA, 8'h00, 0);
    checkOutput("limpio_dato", 32'(if_a.dato_corregido), 32'hB);
    applyStimulus(8'hAA, 8'h20, 0);
    checkOutput("simple_rec", 32'(if_a.recibido), 32'h8A);
    checkOutput("simple_pos", 32'(if_a.posicion_error), 32'd5);
    checkOutput("simple_cont", 32'(if_a.contador_simple), 32'd1);
    applyStimulus(8'hAA, 8'h01, 0);
    checkOutput("paridad_rec", 32'(if_a.recibido), 32'hAB);
    checkOutput("paridad_pos", 32'(if_a.posicion_error), 32'd0);
    applyStimulus(8'hAA, 8'h06, 0);
    checkOutput("doble_pos", 32'(if_a.posicion_error), 32'd3);
    checkOutput("doble_cont", 32'(if_a.contador_doble), 32'd1);
    checkOutput("noinj_flags", 32'({if_c.error_simple, if_c.error_doble}), 32'd0);
    applyStimulus(8'hAA, 8'h40, 10);
    applyStimulus(8'hAA, 8'h08, 0);
    applyStimulus(8'h33, 8'h80, 0);
    checkOutput("saturacion", 32'(if_b.contador_simple), 32'd3);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'($urandom), 8'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7))), k % 2);
    end
    resetMidDecode();
    applyStimulus(8'hAA, 8'h20, 0);
    checkOutput("cont_tras_reset", 32'(if_a.contador_simple), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
